codec_access_arbiter: RTL and testbench
=======================================

Name: codec_access_arbiter

Overview:
- Shares the single codec register RD/WR port of the codec controller unit between NUM_REQ independent requesters, e.g. the PS register bank, the volume ramp engine and the sample-rate switcher.
- Blocks all grants until codec initialization has finished, with init_done or init_error.
- Grants round-robin and issues exactly one single-cycle rd/wr strobe per transaction.
- Tracks controller_busy to completion and returns read data plus an error flag to the owning requester.

Parameters:
- NUM_REQ, 3, number of requesters (2..8).
- TIMEOUT_CYCLES, 100000, max clk cycles from busy rise to busy fall before abort.
- START_LIMIT, 16, max cycles from strobe to busy rise before abort.

Ports:
- clk  in  1  system clock (125 MHz).
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request; held with fields stable until req_ready.
- req_write  in  NUM_REQ  1=write, 0=read.
- req_addr  in  8*NUM_REQ  codec register address, requester i at [8i+7:8i].
- req_wdata  in  9*NUM_REQ  write data, requester i at [9i+8:9i].
- req_ready  out  NUM_REQ  one-cycle accept pulse to the granted requester.
- rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- rsp_rdata  out  9  read data, valid with rsp_valid.
- rsp_error  out  1  missed ACK, start timeout or done timeout, valid with rsp_valid.
- codec_rd_en  out  1  read strobe to the controller.
- codec_wr_en  out  1  write strobe to the controller.
- codec_reg_addr  out  8  address to the controller.
- codec_data_in  out  9  write data to the controller.
- codec_data_out  in  9  read data from the controller.
- codec_data_out_valid  in  1  read data qualifier.
- controller_busy  in  1  controller busy.
- missed_ack  in  1  I2C NACK indication.
- init_done  in  1  codec init complete.
- init_error  in  1  codec init failed.
- arb_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, active-high) values: all outputs 0, state=IDLE, grant pointer=NUM_REQ-1 so requester 0 wins first, counters 0. Reset asserted mid-transaction aborts it immediately; no rsp_valid is produced.
- IDLE:
  - No grant while (init_done|init_error)==0 or controller_busy==1.
  - Otherwise pick the first asserted req_valid, searching from pointer+1 with wrap.
  - Latch write/addr/wdata and the grant index g, pulse req_ready[g], update pointer=g, go to ISSUE.
  - The winner is decided in the same cycle that req_valid is sampled; a request dropped before the grant is simply not served.
- ISSUE:
  - Assert codec_wr_en (write) or codec_rd_en (read) for exactly 1 cycle.
  - codec_reg_addr/codec_data_in hold the latched values from ISSUE through WAIT_DONE, and remain at the last value otherwise.
  - Clear the sticky error/valid flags, go to WAIT_BUSY.
- WAIT_BUSY: controller_busy=1 moves to WAIT_DONE. Otherwise count; at START_LIMIT cycles set error and go to RESPOND.
- WAIT_DONE:
  - Capture codec_data_out on any cycle with codec_data_out_valid=1; the last capture wins.
  - missed_ack=1 on any cycle sets sticky error.
  - controller_busy=0 moves to RESPOND.
  - Counter reaching TIMEOUT_CYCLES sets error and moves to RESPOND.
- RESPOND:
  - Pulse rsp_valid[g] for 1 cycle and go to IDLE.
  - rsp_rdata is the captured data for a read whose valid was seen. Otherwise it is 0; for a read this also sets rsp_error.
  - Write rsp_rdata is always 0.
- Latency: from req_valid to req_ready is 1 cycle when idle. The earliest back-to-back grant is the cycle after RESPOND.
- rsp_rdata/rsp_error hold until the next RESPOND.
- Counter width is $clog2(max(TIMEOUT_CYCLES,START_LIMIT)+1) and saturates; there is no wrap.
- Only one transaction is outstanding at any time.
- req_ready and rsp_valid are one-hot or zero.
- codec_rd_en and codec_wr_en are never asserted together.

Decomposition:
- Package codec_arb_pkg: state enum (IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND), ADDR_W=8, DATA_W=9, default START_LIMIT.
- Sub-module rr_arbiter, parameter N:
  - Inputs: request vector and pointer.
  - Outputs: one-hot grant and index, combinational.
  - Pointer register stays in the top.

Test Plan:
- init_done=0, req_valid=3'b001 -> no req_ready and no strobe. Then init_done=1 -> req_ready[0] on the next cycle, codec_rd_en 1-cycle pulse.
- All three requesters hold req_valid; controller model busies 20 cycles per op -> grant order 0,1,2,0,1,2 with exactly one strobe each and no overlap.
- Req1 read addr 8'h07; model returns codec_data_out=9'h0A5 with valid -> rsp_valid=3'b010, rsp_rdata=9'h0A5, rsp_error=0.
- Req2 write addr 8'h02 data 9'h179; model pulses missed_ack -> rsp_valid[2], rsp_error=1, rsp_rdata=0; codec_data_in=9'h179 stable through WAIT_DONE.
- Model never raises busy -> rsp_error=1 after START_LIMIT=16 cycles. Model holds busy forever with TIMEOUT_CYCLES=50 -> rsp_error=1 at cycle 50. Arbiter returns to IDLE in both cases.
- Assert reset during WAIT_DONE -> all outputs 0 asynchronously, no rsp_valid. After release, requester 0 has priority.

Source files
------------

// File: rtl/codec_arb_pkg.sv
// codec_arb_pkg: shared types and constants for the codec access arbiter.
// Holds the arbiter FSM state encoding and codec register field widths.
package codec_arb_pkg;

    localparam int ADDR_W             = 8;
    localparam int DATA_W             = 9;
    localparam int DEF_START_LIMIT    = 16;
    localparam int DEF_TIMEOUT_CYCLES = 100000;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_BUSY,
        WAIT_DONE,
        RESPOND
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching from ptr+1 with wrap.
// Ports: req (request vector), ptr (last winner), grant (one-hot), idx, valid.
module rr_arbiter #(
    parameter int N = 3
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 valid
);

    always_comb begin
        int c;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        c     = 0;
        // k = N lands back on ptr itself, so the last winner goes last
        for (int k = 1; k <= N; k++) begin
            c = (int'(ptr) + k) % N;
            if (!valid && req[c]) begin
                valid    = 1'b1;
                grant[c] = 1'b1;
                idx      = ($clog2(N))'(c);
            end
        end
    end

endmodule

// File: rtl/codec_access_arbiter.sv
// codec_access_arbiter: shares the codec controller register port among
// NUM_REQ requesters, round-robin, one transaction outstanding at a time.
// Ports: req_valid/req_write/req_addr/req_wdata/req_ready (request side),
// rsp_valid/rsp_rdata/rsp_error (response side), codec_* (controller port),
// controller_busy/missed_ack (controller status), init_done/init_error
// (grant gate), arb_busy (high outside IDLE).
module codec_access_arbiter
    import codec_arb_pkg::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int START_LIMIT    = DEF_START_LIMIT
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [ADDR_W*NUM_REQ-1:0] req_addr,
    input  logic [DATA_W*NUM_REQ-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_error,
    output logic                      codec_rd_en,
    output logic                      codec_wr_en,
    output logic [ADDR_W-1:0]         codec_reg_addr,
    output logic [DATA_W-1:0]         codec_data_in,
    input  logic [DATA_W-1:0]         codec_data_out,
    input  logic                      codec_data_out_valid,
    input  logic                      controller_busy,
    input  logic                      missed_ack,
    input  logic                      init_done,
    input  logic                      init_error,
    output logic                      arb_busy
);

    localparam int IW    = $clog2(NUM_REQ);
    localparam int LIM   = (TIMEOUT_CYCLES > START_LIMIT) ?
                           TIMEOUT_CYCLES : START_LIMIT;
    localparam int CNT_W = $clog2(LIM + 1);

    state_t             state, state_n;
    logic [IW-1:0]      ptr_q, ptr_n, g_q, g_n;
    logic               wr_q, wr_n;
    logic [ADDR_W-1:0]  addr_q, addr_n;
    logic [DATA_W-1:0]  wdata_q, wdata_n;
    logic [DATA_W-1:0]  cap_q, cap_n, rdata_q, rdata_n;
    logic               err_q, err_n, dv_q, dv_n, rerr_q, rerr_n;
    logic [CNT_W-1:0]   cnt_q, cnt_n, cnt_inc;
    logic [NUM_REQ-1:0] rdy_q, rdy_n, arb_grant;
    logic [IW-1:0]      arb_idx;
    logic               arb_any, can_grant;

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (arb_grant),
        .idx   (arb_idx),
        .valid (arb_any)
    );

    assign can_grant = (init_done | init_error) & ~controller_busy;
    assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_n = state;
        ptr_n   = ptr_q;
        g_n     = g_q;
        wr_n    = wr_q;
        addr_n  = addr_q;
        wdata_n = wdata_q;
        cnt_n   = cnt_q;
        err_n   = err_q;
        dv_n    = dv_q;
        cap_n   = cap_q;
        rdy_n   = '0;
        rdata_n = rdata_q;
        rerr_n  = rerr_q;
        unique case (state)
            IDLE: begin
                if (can_grant && arb_any) begin
                    g_n     = arb_idx;
                    ptr_n   = arb_idx;
                    wr_n    = req_write[arb_idx];
                    addr_n  = req_addr[int'(arb_idx)*ADDR_W +: ADDR_W];
                    wdata_n = req_wdata[int'(arb_idx)*DATA_W +: DATA_W];
                    rdy_n   = arb_grant;
                    state_n = ISSUE;
                end
            end
            ISSUE: begin
                err_n   = 1'b0;
                dv_n    = 1'b0;
                cap_n   = '0;
                cnt_n   = '0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (controller_busy) begin
                    cnt_n   = '0;
                    state_n = WAIT_DONE;
                end else if (int'(cnt_q) + 1 >= START_LIMIT) begin
                    err_n   = 1'b1;
                    state_n = RESPOND;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            WAIT_DONE: begin
                if (codec_data_out_valid) begin
                    dv_n  = 1'b1;
                    cap_n = codec_data_out;
                end
                if (missed_ack) err_n = 1'b1;
                if (!controller_busy) begin
                    state_n = RESPOND;
                end else if (int'(cnt_q) + 1 >= TIMEOUT_CYCLES) begin
                    err_n   = 1'b1;
                    state_n = RESPOND;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            RESPOND: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        // Response fields are loaded on entry so they are valid alongside
        // rsp_valid; a read that never saw data reports an error.
        if (state != RESPOND && state_n == RESPOND) begin
            rdata_n = (!wr_n && dv_n) ? cap_n : '0;
            rerr_n  = err_n | (!wr_n && !dv_n);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            ptr_q   <= IW'(NUM_REQ - 1);
            g_q     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            dv_q    <= 1'b0;
            cap_q   <= '0;
            rdy_q   <= '0;
            rdata_q <= '0;
            rerr_q  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr_q   <= ptr_n;
            g_q     <= g_n;
            wr_q    <= wr_n;
            addr_q  <= addr_n;
            wdata_q <= wdata_n;
            cnt_q   <= cnt_n;
            err_q   <= err_n;
            dv_q    <= dv_n;
            cap_q   <= cap_n;
            rdy_q   <= rdy_n;
            rdata_q <= rdata_n;
            rerr_q  <= rerr_n;
        end
    end

    assign req_ready      = rdy_q;
    assign rsp_valid      = (state == RESPOND) ? (NUM_REQ'(1) << g_q) : '0;
    assign rsp_rdata      = rdata_q;
    assign rsp_error      = rerr_q;
    assign codec_rd_en    = (state == ISSUE) & ~wr_q;
    assign codec_wr_en    = (state == ISSUE) & wr_q;
    assign codec_reg_addr = addr_q;
    assign codec_data_in  = wdata_q;
    assign arb_busy       = (state != IDLE);

endmodule

// File: tb/tb_codec_access_arbiter.sv
// tb_codec_access_arbiter: self-checking bench with a controller model,
// a response scoreboard, a vector table and hand-written corner sequences.
module tb_codec_access_arbiter;

    localparam int NR = 3;
    localparam int TO = 50;
    localparam int SL = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_valid = '0;
    logic [NR-1:0]   req_write = '0;
    logic [8*NR-1:0] req_addr = '0;
    logic [9*NR-1:0] req_wdata = '0;
    logic [NR-1:0]   req_ready, rsp_valid;
    logic [8:0]      rsp_rdata;
    logic            rsp_error;
    logic            codec_rd_en, codec_wr_en;
    logic [7:0]      codec_reg_addr;
    logic [8:0]      codec_data_in;
    logic [8:0]      codec_data_out = 9'h1EE;
    logic            codec_data_out_valid = 1'b0;
    logic            controller_busy = 1'b0;
    logic            missed_ack = 1'b0;
    logic            init_done = 1'b0;
    logic            init_error = 1'b0;
    logic            arb_busy;

    codec_access_arbiter #(
        .NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .START_LIMIT(SL)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .codec_rd_en(codec_rd_en), .codec_wr_en(codec_wr_en),
        .codec_reg_addr(codec_reg_addr), .codec_data_in(codec_data_in),
        .codec_data_out(codec_data_out),
        .codec_data_out_valid(codec_data_out_valid),
        .controller_busy(controller_busy), .missed_ack(missed_ack),
        .init_done(init_done), .init_error(init_error),
        .arb_busy(arb_busy)
    );

    always #4 clk = ~clk;

    typedef enum int {M_NORMAL, M_NOBUSY, M_FOREVER} mode_e;

    typedef struct {
        int         idx;
        bit         wr;
        logic [7:0] addr;
        logic [8:0] wdata;
        mode_e      mode;
        bit         give;
        bit         nack;
        logic [8:0] mrd;
        logic [8:0] erd;
        bit         eerr;
        int         lmin;
        int         lmax;
    } vec_t;

    typedef struct {
        logic [NR-1:0] oh;
        logic [8:0]    rd;
        bit            err;
        int            lmin;
        int            lmax;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   strobe_cyc = 0;
    int   n_grant = 0;
    int   n_strobe = 0;

    mode_e      m_mode = M_NORMAL;
    int         m_len = 20;
    bit         m_give = 1'b0;
    bit         m_nack = 1'b0;
    bit         m_chk = 1'b0;
    logic [8:0] m_rd = '0;
    logic [7:0] m_eaddr = '0;
    logic [8:0] m_ewd = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Controller model: reacts to each strobe according to m_mode.
    initial begin : model
        bit rd;
        bit ok;
        forever begin
            @(negedge clk);
            if (!reset && (codec_rd_en || codec_wr_en)) begin
                rd = codec_rd_en;
                ok = 1'b1;
                if (m_mode == M_NORMAL) begin
                    @(posedge clk);
                    #1 controller_busy = 1'b1;
                    for (int i = 0; i < m_len; i++) begin
                        @(posedge clk);
                        #1;
                        codec_data_out_valid = rd && m_give && (i == 1);
                        codec_data_out = codec_data_out_valid ? m_rd : 9'h1EE;
                        missed_ack = m_nack && (i == 3);
                        if (codec_reg_addr !== m_eaddr ||
                            codec_data_in !== m_ewd) ok = 1'b0;
                    end
                    controller_busy      = 1'b0;
                    codec_data_out_valid = 1'b0;
                    missed_ack           = 1'b0;
                    codec_data_out       = 9'h1EE;
                    if (m_chk) check("hold_addr_data", 64'(ok), 64'd1);
                end else if (m_mode == M_FOREVER) begin
                    @(posedge clk);
                    #1 controller_busy = 1'b1;
                    for (int c = 0; c < 300 && rsp_valid == '0; c++)
                        @(negedge clk);
                    @(posedge clk);
                    #1 controller_busy = 1'b0;
                end
            end
        end
    end

    // Monitor: invariants every cycle, scoreboard pop on each response.
    initial begin : monitor
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (!reset) begin
                check("ready_onehot", 64'($countones(req_ready) <= 1), 64'd1);
                check("strobe_excl", 64'(codec_rd_en & codec_wr_en), 64'd0);
                if (req_ready != '0) n_grant++;
                if (codec_rd_en || codec_wr_en) begin
                    n_strobe++;
                    strobe_cyc = cyc;
                end
                if (rsp_valid != '0) begin
                    if (sbq.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_rsp: rsp_valid=%b, none pending",
                                 rsp_valid);
                    end else begin
                        e   = sbq.pop_front();
                        lat = cyc - strobe_cyc;
                        check("rsp_valid", 64'(rsp_valid), 64'(e.oh));
                        check("rsp_rdata", 64'(rsp_rdata), 64'(e.rd));
                        check("rsp_error", 64'(rsp_error), 64'(e.err));
                        n_tests++;
                        if (lat < e.lmin || lat > e.lmax) begin
                            n_fail++;
                            $display("FAIL rsp_latency: got %0d, required %0d..%0d",
                                     lat, e.lmin, e.lmax);
                        end
                    end
                end
            end
        end
    end

    task automatic push_exp(input int idx, input logic [8:0] rd, input bit err,
                            input int lmin, input int lmax);
        exp_t e;
        e.oh   = NR'(1) << idx;
        e.rd   = rd;
        e.err  = err;
        e.lmin = lmin;
        e.lmax = lmax;
        sbq.push_back(e);
    endtask

    task automatic set_req(input int idx, input bit wr, input logic [7:0] a,
                           input logic [8:0] d);
        req_write[idx]        = wr;
        req_addr[idx*8 +: 8]  = a;
        req_wdata[idx*9 +: 9] = d;
    endtask

    task automatic wait_grant();
        bit got;
        got = 1'b0;
        for (int c = 0; c < 300 && !got; c++) begin
            @(negedge clk);
            got = (req_ready != '0);
        end
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 300 && sbq.size() != 0; c++) @(negedge clk);
        check("drain", 64'(sbq.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic run_vec(input vec_t v);
        m_mode  = v.mode;
        m_len   = 20;
        m_give  = v.give;
        m_nack  = v.nack;
        m_rd    = v.mrd;
        m_chk   = 1'b1;
        m_eaddr = v.addr;
        m_ewd   = v.wdata;
        push_exp(v.idx, v.erd, v.eerr, v.lmin, v.lmax);
        set_req(v.idx, v.wr, v.addr, v.wdata);
        req_valid[v.idx] = 1'b1;
        wait_grant();
        check("vec_grant", 64'(req_ready), 64'(NR'(1) << v.idx));
        req_valid[v.idx] = 1'b0;
        wait_drain();
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[7];
    int   last;
    bit   seen;

    initial begin : stim
        tbl[0] = '{1, 1'b0, 8'h07, 9'h000, M_NORMAL,  1'b1, 1'b0,
                   9'h0A5, 9'h0A5, 1'b0, 0, 1000};
        tbl[1] = '{2, 1'b1, 8'h02, 9'h179, M_NORMAL,  1'b0, 1'b1,
                   9'h000, 9'h000, 1'b1, 0, 1000};
        tbl[2] = '{0, 1'b1, 8'h33, 9'h0FF, M_NORMAL,  1'b0, 1'b0,
                   9'h000, 9'h000, 1'b0, 0, 1000};
        tbl[3] = '{1, 1'b0, 8'h40, 9'h000, M_NORMAL,  1'b0, 1'b0,
                   9'h000, 9'h000, 1'b1, 0, 1000};
        tbl[4] = '{0, 1'b0, 8'h11, 9'h000, M_NOBUSY,  1'b0, 1'b0,
                   9'h000, 9'h000, 1'b1, SL, SL + 2};
        tbl[5] = '{1, 1'b1, 8'h22, 9'h1AA, M_FOREVER, 1'b0, 1'b0,
                   9'h000, 9'h000, 1'b1, TO, TO + 3};
        tbl[6] = '{2, 1'b0, 8'h5A, 9'h000, M_NORMAL,  1'b1, 1'b1,
                   9'h1C3, 9'h1C3, 1'b1, 0, 1000};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {28'd0, req_ready, rsp_valid, rsp_rdata, rsp_error, codec_rd_en,
               codec_wr_en, codec_reg_addr, codec_data_in, arb_busy}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Grants held off until init completes
        m_mode = M_NORMAL; m_len = 20; m_give = 1'b1; m_nack = 1'b0;
        m_rd = 9'h13C; m_chk = 1'b1; m_eaddr = 8'h21; m_ewd = 9'h000;
        push_exp(0, 9'h13C, 1'b0, 0, 1000);
        set_req(0, 1'b0, 8'h21, 9'h000);
        req_valid = 3'b001;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (req_ready != '0) seen = 1'b1;
        end
        check("gate_ready", 64'(seen), 64'd0);
        check("gate_strobe", 64'(n_strobe), 64'd0);
        init_done = 1'b1;
        @(negedge clk);
        check("init_grant", 64'(req_ready), 64'b001);
        check("init_rd_strobe", {63'd0, codec_rd_en}, 64'd1);
        req_valid = '0;
        @(negedge clk);
        check("rd_pulse_1cyc", {63'd0, codec_rd_en}, 64'd0);
        wait_drain();

        // Reset during WAIT_DONE; requester 0 wins again afterwards
        m_mode = M_NORMAL; m_len = 30; m_give = 1'b1; m_nack = 1'b0;
        m_rd = 9'h055; m_chk = 1'b0;
        set_req(0, 1'b0, 8'h30, 9'h000);
        req_valid[0] = 1'b1;
        wait_grant();
        req_valid[0] = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_busy", {63'd0, arb_busy}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("async_reset",
              {28'd0, req_ready, rsp_valid, rsp_rdata, rsp_error, codec_rd_en,
               codec_wr_en, codec_reg_addr, codec_data_in, arb_busy}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_exp(0, 9'h055, 1'b0, 0, 1000);
        set_req(0, 1'b0, 8'h31, 9'h000);
        set_req(1, 1'b0, 8'h32, 9'h000);
        set_req(2, 1'b0, 8'h33, 9'h000);
        req_valid = '1;
        wait_grant();
        check("post_reset_prio", 64'(req_ready), 64'b001);
        req_valid = '0;
        wait_drain();

        // Single-request vector table
        for (int i = 0; i < 7; i++) run_vec(tbl[i]);

        // Round-robin with all requesters held
        last = tbl[6].idx;
        m_mode = M_NORMAL; m_len = 20; m_give = 1'b1; m_nack = 1'b0;
        m_rd = 9'h0C3; m_chk = 1'b0;
        for (int k = 0; k < 6; k++)
            push_exp((last + 1 + k) % NR, 9'h0C3, 1'b0, 0, 1000);
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 8'(8'h10 + i), 9'h000);
        req_valid = '1;
        for (int k = 0; k < 6; k++) begin
            wait_grant();
            if (k == 5) req_valid = '0;
            check("rr_order", 64'(req_ready),
                  64'(NR'(1) << ((last + 1 + k) % NR)));
        end
        wait_drain();

        check("strobe_per_grant", 64'(n_strobe), 64'(n_grant));
        check("sb_empty", 64'(sbq.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
